// File: rtl/ball_motion.sv
// Game-rate ball mover: synchronises the divided tick clock into clk_in, then steps
// the ball one pixel per axis per tick with wall, paddle and brick bounces and loss detection.
module ball_motion #(
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 8,
    parameter int START_X   = 316,
    parameter int START_Y   = 400,
    parameter int PADDLE_Y  = 440,
    parameter int PADDLE_W  = 64
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic           tick_clk,
    input  logic           launch,
    input  logic [X_W-1:0] paddle_x,
    input  logic           brick_hit,
    output logic [X_W-1:0] ball_x,
    output logic [Y_W-1:0] ball_y,
    output logic           dir_x,
    output logic           dir_y,
    output logic           in_play,
    output logic           ball_lost
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        LOST  = 2'd2
    } state_t;

    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_ONE   = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);
    localparam logic [X_W:0]   X_MAX   = (X_W+1)'(SCREEN_W - BALL_SIZE);
    localparam logic [Y_W:0]   Y_MAX   = (Y_W+1)'(SCREEN_H - BALL_SIZE);
    localparam logic [X_W:0]   X_BALL  = (X_W+1)'(BALL_SIZE);
    localparam logic [Y_W:0]   Y_BALL  = (Y_W+1)'(BALL_SIZE);
    localparam logic [Y_W:0]   Y_PAD   = (Y_W+1)'(PADDLE_Y);
    localparam logic [X_W:0]   X_PADW  = (X_W+1)'(PADDLE_W);

    state_t         state;
    logic           s1, s2, s3;
    logic           tick;
    logic           brick_pend;

    logic [X_W:0]   bx, px;
    logic [Y_W:0]   by;
    logic           dy_eff;
    logic           paddle_hit;
    logic           lose;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           ndx, ndy;

    // A pending brick hit and one landing on the tick cycle merge into a single flip.
    always_comb begin
        tick       = s2 & ~s3;
        bx         = {1'b0, ball_x};
        px         = {1'b0, paddle_x};
        by         = {1'b0, ball_y};
        dy_eff     = dir_y ^ (brick_pend | brick_hit);
        paddle_hit = ((by + Y_BALL) == Y_PAD) && ((bx + X_BALL) > px) && (bx < (px + X_PADW));
        lose       = 1'b0;
        nx         = ball_x;
        ny         = ball_y;
        ndx        = dir_x;
        ndy        = dy_eff;

        if (dir_x && (bx == X_MAX)) begin
            ndx = 1'b0;
            nx  = ball_x - X_ONE;
        end else if (!dir_x && (ball_x == '0)) begin
            ndx = 1'b1;
            nx  = ball_x + X_ONE;
        end else if (dir_x) begin
            nx  = ball_x + X_ONE;
        end else begin
            nx  = ball_x - X_ONE;
        end

        if (!dy_eff) begin
            if (ball_y == '0) begin
                ndy = 1'b1;
                ny  = ball_y + Y_ONE;
            end else begin
                ny  = ball_y - Y_ONE;
            end
        end else if (paddle_hit) begin
            ndy = 1'b0;
            ny  = ball_y - Y_ONE;
        end else if (by == Y_MAX) begin
            lose = 1'b1;
        end else begin
            ny  = ball_y + Y_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SERVE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            brick_pend <= 1'b0;
            ball_x     <= X_START;
            ball_y     <= Y_START;
            dir_x      <= 1'b1;
            dir_y      <= 1'b0;
            in_play    <= 1'b0;
            ball_lost  <= 1'b0;
        end else begin
            s1        <= tick_clk;
            s2        <= s1;
            s3        <= s2;
            ball_lost <= 1'b0;
            case (state)
                SERVE: begin
                    ball_x     <= X_START;
                    ball_y     <= Y_START;
                    brick_pend <= 1'b0;
                    if (launch) begin
                        state   <= MOVE;
                        in_play <= 1'b1;
                        dir_x   <= 1'b1;
                        dir_y   <= 1'b0;
                    end
                end
                MOVE: begin
                    if (tick) begin
                        brick_pend <= 1'b0;
                        if (lose) begin
                            state     <= LOST;
                            in_play   <= 1'b0;
                            ball_lost <= 1'b1;
                        end else begin
                            ball_x <= nx;
                            ball_y <= ny;
                            dir_x  <= ndx;
                            dir_y  <= ndy;
                        end
                    end else if (brick_hit) begin
                        brick_pend <= 1'b1;
                    end
                end
                LOST: begin
                    state      <= SERVE;
                    ball_x     <= X_START;
                    ball_y     <= Y_START;
                    dir_x      <= 1'b1;
                    dir_y      <= 1'b0;
                    brick_pend <= 1'b0;
                    in_play    <= 1'b0;
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: table of trajectory segments with hand-computed
// positions, plus hand sequences for reset, tick timing, paddle edges and loss.
module tb_ball_motion;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       tick_clk;
    logic       launch;
    logic [9:0] paddle_x;
    logic       brick_hit;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       dir_x, dir_y, in_play, ball_lost;

    int n_cmp = 0;
    int n_bad = 0;

    ball_motion dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick_clk  (tick_clk),
        .launch    (launch),
        .paddle_x  (paddle_x),
        .brick_hit (brick_hit),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .in_play   (in_play),
        .ball_lost (ball_lost)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int ticks;
        int pulses;
        int tick_brick;
        int ex, ey, edx, edy;
    } seg_t;

    typedef struct {
        int px;
        int ey, edy;
    } pad_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int ey, input int edx,
                           input int edy, input int eplay);
        chk({tag, ".x"}, int'(ball_x), ex);
        chk({tag, ".y"}, int'(ball_y), ey);
        chk({tag, ".dir_x"}, int'(dir_x), edx);
        chk({tag, ".dir_y"}, int'(dir_y), edy);
        chk({tag, ".in_play"}, int'(in_play), eplay);
    endtask

    // Full divided-clock pulse; ends on a negedge with all sync flops low again.
    task automatic do_tick(input int brick_on_tick);
        @(negedge clk_in) tick_clk = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in) if (brick_on_tick != 0) brick_hit = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        brick_hit = 1'b0;
        tick_clk  = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic pulse_brick();
        @(negedge clk_in) brick_hit = 1'b1;
        @(negedge clk_in) brick_hit = 1'b0;
    endtask

    task automatic serve_and_dive();
        @(negedge clk_in) rst_n = 1'b0;
        paddle_x = '0;
        @(negedge clk_in) rst_n = 1'b1;
        @(negedge clk_in) launch = 1'b1;
        @(negedge clk_in) launch = 1'b0;
        pulse_brick();
        repeat (32) do_tick(0);
        chk_all("dive", 348, 432, 1, 1, 1);
    endtask

    seg_t segs[11];
    pad_t pads[5];

    initial begin
        segs[0]  = '{1,   0, 0, 318, 398, 1, 0};
        segs[1]  = '{313, 0, 0, 631, 85,  1, 0};
        segs[2]  = '{1,   0, 0, 632, 84,  1, 0};
        segs[3]  = '{1,   0, 0, 631, 83,  0, 0};
        segs[4]  = '{1,   3, 0, 630, 84,  0, 1};
        segs[5]  = '{273, 0, 0, 357, 357, 0, 1};
        segs[6]  = '{1,   1, 0, 356, 356, 0, 0};
        segs[7]  = '{355, 0, 0, 1,   1,   0, 0};
        segs[8]  = '{1,   0, 0, 0,   0,   0, 0};
        segs[9]  = '{1,   0, 0, 1,   1,   1, 1};
        segs[10] = '{1,   0, 1, 2,   0,   1, 0};

        pads[0] = '{338, 431, 0};
        pads[1] = '{400, 433, 1};
        pads[2] = '{356, 433, 1};
        pads[3] = '{285, 431, 0};
        pads[4] = '{284, 433, 1};

        rst_n = 1'b0; tick_clk = 1'b0; launch = 1'b0; paddle_x = '0; brick_hit = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk_all("reset", 316, 400, 1, 0, 0);
        chk("reset.ball_lost", int'(ball_lost), 0);
        rst_n = 1'b1;

        do_tick(0);
        do_tick(0);
        chk_all("serve_idle", 316, 400, 1, 0, 0);

        @(negedge clk_in) launch = 1'b1;
        @(negedge clk_in) launch = 1'b0;
        chk("launch.in_play", int'(in_play), 1);

        tick_clk = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in) chk("lat1.y", int'(ball_y), 400);
        @(posedge clk_in);
        @(negedge clk_in) chk("lat2.y", int'(ball_y), 400);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("lat3.x", int'(ball_x), 317);
        chk("lat3.y", int'(ball_y), 399);
        repeat (50) @(posedge clk_in);
        @(negedge clk_in);
        chk("hold.x", int'(ball_x), 317);
        chk("hold.y", int'(ball_y), 399);
        tick_clk = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);

        for (int i = 0; i < 11; i++) begin
            for (int p = 0; p < segs[i].pulses; p++) pulse_brick();
            for (int t = 0; t < segs[i].ticks; t++)
                do_tick((t == segs[i].ticks - 1) ? segs[i].tick_brick : 0);
            chk_all($sformatf("seg%0d", i), segs[i].ex, segs[i].ey, segs[i].edx, segs[i].edy, 1);
        end

        do_tick(0);
        chk_all("top_bounce", 3, 1, 1, 1, 1);

        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 316, 400, 1, 0, 0);
        @(negedge clk_in) rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            serve_and_dive();
            @(negedge clk_in) paddle_x = 10'(pads[i].px);
            do_tick(0);
            chk_all($sformatf("paddle%0d", pads[i].px), 349, pads[i].ey, 1, pads[i].edy, 1);
        end

        paddle_x = '0;
        repeat (39) do_tick(0);
        chk_all("pre_loss", 388, 472, 1, 1, 1);
        @(negedge clk_in) tick_clk = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("loss.ball_lost", int'(ball_lost), 1);
        chk("loss.in_play", int'(in_play), 0);
        chk("loss.x", int'(ball_x), 388);
        chk("loss.y", int'(ball_y), 472);
        tick_clk = 1'b0;
        @(negedge clk_in);
        chk("after_loss.ball_lost", int'(ball_lost), 0);
        chk_all("after_loss", 316, 400, 1, 0, 0);
        do_tick(0);
        do_tick(0);
        chk_all("serve_again", 316, 400, 1, 0, 0);
        chk("serve_again.ball_lost", int'(ball_lost), 0);
        @(negedge clk_in) launch = 1'b1;
        @(negedge clk_in) launch = 1'b0;
        chk("relaunch.in_play", int'(in_play), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
